// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: control FSM states, decode-mode encodings
// and compare-flag bit positions.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } fetch_state_t;

    localparam logic [1:0] MODE_REG    = 2'b00;
    localparam logic [1:0] MODE_TARGET = 2'b01;
    localparam logic [1:0] MODE_IMM    = 2'b10;
    localparam logic [1:0] MODE_NOP    = 2'b11;

    localparam int unsigned CMP_ZERO = 2;
    localparam int unsigned CMP_EQ   = 1;
    localparam int unsigned CMP_GT   = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Decoder/harness <-> fetch unit signal bundle. The master side is the decoder plus
// the test harness; the slave side is the fetch unit.
interface fetch_unit_if #(
    parameter int unsigned PC_W = 10
);
    logic            Start;
    logic            BranchEn;
    logic [8:0]      BranchTarget;
    logic [1:0]      NextState;
    logic [8:0]      PrevInstructionOut;
    logic            CMPLoadEn;
    logic [2:0]      CMPBitsOut;
    logic            Ack;
    logic [PC_W-1:0] ProgCtr;
    logic [1:0]      CurrState;
    logic [8:0]      PrevInstruction;
    logic [2:0]      CMPBits;
    logic            Running;
    logic            Done;
    logic            PCWrapErr;
    logic [15:0]     CycleCount;

    modport master (
        output Start, BranchEn, BranchTarget, NextState, PrevInstructionOut,
               CMPLoadEn, CMPBitsOut, Ack,
        input  ProgCtr, CurrState, PrevInstruction, CMPBits, Running, Done,
               PCWrapErr, CycleCount
    );

    modport slave (
        input  Start, BranchEn, BranchTarget, NextState, PrevInstructionOut,
               CMPLoadEn, CMPBitsOut, Ack,
        output ProgCtr, CurrState, PrevInstruction, CMPBits, Running, Done,
               PCWrapErr, CycleCount
    );
endinterface

// File: rtl/fetch_unit_run_counter.sv
// Saturating 16-bit count of RUN cycles; cleared when a program starts.
module fetch_unit_run_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Program counter and registered decode context feeding the control decoder.
// Define FETCH_CYCLE_COUNT_EN to build the RUN-cycle counter on CycleCount.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.slave  bus
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      mode_q, mode_d;
    logic [8:0]      prev_q, prev_d;
    logic [2:0]      cmp_q, cmp_d;
    logic            wrap_q, wrap_d;
    logic            start_clr;
    logic            cnt_inc;
    logic [PC_W-1:0] target_ext;
    logic [15:0]     cycle_count;

    // Size cast zero-extends or truncates the 9-bit target depending on PC_W.
    assign target_ext = PC_W'(bus.BranchTarget);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mode_d    = mode_q;
        prev_d    = prev_q;
        cmp_d     = cmp_q;
        wrap_d    = wrap_q;
        start_clr = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_d   = RUN;
                    pc_d      = PC_W'(START_ADDR);
                    mode_d    = MODE_REG;
                    prev_d    = '0;
                    cmp_d     = '0;
                    wrap_d    = 1'b0;
                    start_clr = 1'b1;
                end
            end
            RUN: begin
                cnt_inc = 1'b1;
                // Ack freezes the context so ProgCtr keeps addressing the done instruction.
                if (bus.Ack) begin
                    state_d = DONE;
                end else begin
                    if (bus.BranchEn) begin
                        pc_d = target_ext;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                        if (pc_q == {PC_W{1'b1}}) begin
                            wrap_d = 1'b1;
                        end
                    end
                    mode_d = bus.NextState;
                    prev_d = bus.PrevInstructionOut;
                    if (bus.CMPLoadEn) begin
                        cmp_d = bus.CMPBitsOut;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= PC_W'(START_ADDR);
            mode_q  <= MODE_REG;
            prev_q  <= '0;
            cmp_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mode_q  <= mode_d;
            prev_q  <= prev_d;
            cmp_q   <= cmp_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    fetch_unit_run_counter u_run_counter (
        .clk     (Clk),
        .reset_n (Reset),
        .clear   (start_clr),
        .inc     (cnt_inc),
        .count   (cycle_count)
    );
`else
    logic unused_cnt;
    assign unused_cnt  = ^{start_clr, cnt_inc};
    assign cycle_count = '0;
`endif

    assign bus.ProgCtr         = pc_q;
    assign bus.CurrState       = mode_q;
    assign bus.PrevInstruction = prev_q;
    assign bus.CMPBits         = cmp_q;
    assign bus.Running         = (state_q == RUN);
    assign bus.Done            = (state_q == DONE);
    assign bus.PCWrapErr       = wrap_q;
    assign bus.CycleCount      = cycle_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (PC_W=10, START_ADDR=0).
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    fetch_unit_if #(.PC_W(10)) bus ();

    fetch_unit #(
        .PC_W       (10),
        .START_ADDR (0)
    ) dut (
        .Clk   (clk),
        .Reset (reset_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    32'(bus.ProgCtr), 32'd0);
        chk({tag, "_mode"},  32'(bus.CurrState), 32'd0);
        chk({tag, "_prev"},  32'(bus.PrevInstruction), 32'd0);
        chk({tag, "_cmp"},   32'(bus.CMPBits), 32'd0);
        chk({tag, "_run"},   32'(bus.Running), 32'd0);
        chk({tag, "_done"},  32'(bus.Done), 32'd0);
        chk({tag, "_wrap"},  32'(bus.PCWrapErr), 32'd0);
        chk({tag, "_count"}, 32'(bus.CycleCount), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_count;
        reset_n                = 1'b0;
        bus.Start              = 1'b0;
        bus.BranchEn           = 1'b0;
        bus.BranchTarget       = '0;
        bus.NextState          = '0;
        bus.PrevInstructionOut = '0;
        bus.CMPLoadEn          = 1'b0;
        bus.CMPBitsOut         = '0;
        bus.Ack                = 1'b0;

        step();
        step();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        step();
        chk("idle_run", 32'(bus.Running), 32'd0);

        // Sequential fetch
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk("start_run", 32'(bus.Running), 32'd1);
        chk("start_pc", 32'(bus.ProgCtr), 32'd0);
        step();
        chk("seq_pc1", 32'(bus.ProgCtr), 32'd1);
        step();
        chk("seq_pc2", 32'(bus.ProgCtr), 32'd2);
        step();
        chk("seq_pc3", 32'(bus.ProgCtr), 32'd3);
        repeat (4) step();
        chk("seq_pc7", 32'(bus.ProgCtr), 32'd7);

        // Branch redirect
        bus.BranchEn     = 1'b1;
        bus.BranchTarget = 9'h0A5;
        bus.NextState    = 2'b01;
        step();
        bus.BranchEn  = 1'b0;
        bus.NextState = 2'b00;
        chk("br_pc", 32'(bus.ProgCtr), 32'h0A5);
        chk("br_mode", 32'(bus.CurrState), 32'd1);

        // Flag and context commit
        bus.CMPLoadEn          = 1'b1;
        bus.CMPBitsOut         = 3'b110;
        bus.PrevInstructionOut = 9'h1C3;
        step();
        chk("flag_cmp", 32'(bus.CMPBits), 32'b110);
        chk("flag_prev", 32'(bus.PrevInstruction), 32'h1C3);
        chk("flag_pc", 32'(bus.ProgCtr), 32'h0A6);
        chk("flag_mode", 32'(bus.CurrState), 32'd0);
        bus.CMPLoadEn          = 1'b0;
        bus.CMPBitsOut         = 3'b001;
        bus.PrevInstructionOut = 9'h000;
        step();
        chk("hold_cmp", 32'(bus.CMPBits), 32'b110);
        chk("hold_prev", 32'(bus.PrevInstruction), 32'h000);
        bus.CMPBitsOut = 3'b000;

        // Wrap: branch to 0x1FF then count up to 1023
        bus.BranchEn     = 1'b1;
        bus.BranchTarget = 9'h1FF;
        step();
        bus.BranchEn = 1'b0;
        chk("wrapbr_pc", 32'(bus.ProgCtr), 32'h1FF);
        repeat (512) step();
        chk("wrap_pcmax", 32'(bus.ProgCtr), 32'd1023);
        chk("wrap_pre", 32'(bus.PCWrapErr), 32'd0);
        step();
        chk("wrap_pc0", 32'(bus.ProgCtr), 32'd0);
        chk("wrap_err", 32'(bus.PCWrapErr), 32'd1);
        repeat (5) step();
        chk("wrap_sticky", 32'(bus.PCWrapErr), 32'd1);
        chk("wrap_pc5", 32'(bus.ProgCtr), 32'd5);

        // Done priority
        repeat (35) step();
        chk("pre_done_pc", 32'(bus.ProgCtr), 32'd40);
        bus.Ack                = 1'b1;
        bus.BranchEn           = 1'b1;
        bus.BranchTarget       = 9'h010;
        bus.CMPLoadEn          = 1'b1;
        bus.CMPBitsOut         = 3'b001;
        bus.NextState          = 2'b10;
        bus.PrevInstructionOut = 9'h055;
        step();
        bus.Ack = 1'b0;
        chk("done_done", 32'(bus.Done), 32'd1);
        chk("done_run", 32'(bus.Running), 32'd0);
        chk("done_pc", 32'(bus.ProgCtr), 32'd40);
        chk("done_cmp", 32'(bus.CMPBits), 32'b110);
        chk("done_mode", 32'(bus.CurrState), 32'd0);
        chk("done_prev", 32'(bus.PrevInstruction), 32'd0);
        bus.BranchTarget = 9'h033;
        step();
        chk("done_hold_pc", 32'(bus.ProgCtr), 32'd40);
        chk("done_hold", 32'(bus.Done), 32'd1);
        bus.BranchEn           = 1'b0;
        bus.CMPLoadEn          = 1'b0;
        bus.CMPBitsOut         = 3'b000;
        bus.NextState          = 2'b00;
        bus.PrevInstructionOut = 9'h000;

        // Restart from DONE
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk("restart_pc", 32'(bus.ProgCtr), 32'd0);
        chk("restart_done", 32'(bus.Done), 32'd0);
        chk("restart_run", 32'(bus.Running), 32'd1);
        chk("restart_wrap", 32'(bus.PCWrapErr), 32'd0);
        chk("restart_cmp", 32'(bus.CMPBits), 32'd0);
        chk("restart_count", 32'(bus.CycleCount), 32'd0);

        // Start during RUN is ignored
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk("run_start_pc", 32'(bus.ProgCtr), 32'd1);
        repeat (19) step();
        chk("count_pc", 32'(bus.ProgCtr), 32'd20);
`ifdef FETCH_CYCLE_COUNT_EN
        exp_count = 20;
`else
        exp_count = 0;
`endif
        chk("count_val", 32'(bus.CycleCount), 32'(exp_count));

        // Reset mid-run wins over Start and branch
        reset_n          = 1'b0;
        bus.Start        = 1'b1;
        bus.BranchEn     = 1'b1;
        bus.BranchTarget = 9'h0AA;
        step();
        chk_reset_vals("midreset");
        reset_n      = 1'b1;
        bus.Start    = 1'b0;
        bus.BranchEn = 1'b0;
        step();
        chk("post_reset_run", 32'(bus.Running), 32'd0);
        chk("post_reset_pc", 32'(bus.ProgCtr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
